// File: rtl/an_encoder_n13_if.sv
// Handshake bundle for the AN-code encoder: data/mask in, codeword out.
// The slave modport is the encoder; the master modport is the producer/consumer.
interface an_encoder_n13_if #(
   parameter int unsigned DATA_W = 3,
   parameter int unsigned CW_W   = 7
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] data;
   logic [CW_W-1:0]   inj_mask;
   logic              out_valid;
   logic              out_ready;
   logic [CW_W-1:0]   codeword;
   logic              busy;

   modport master (
      output in_valid, data, inj_mask, out_ready,
      input  in_ready, out_valid, codeword, busy
   );

   modport slave (
      input  in_valid, data, inj_mask, out_ready,
      output in_ready, out_valid, codeword, busy
   );
endinterface

// File: rtl/an_encoder_n13.sv
// Serial shift-and-add AN-code encoder: codeword = (data * A) ^ inj_mask.
// One bit of A per cycle, LSB first, so latency is always A_W cycles.
module an_encoder_n13 #(
   parameter int unsigned DATA_W = 3,
   parameter int unsigned A      = 13,
   parameter int unsigned A_W    = 4,
   parameter int unsigned CW_W   = DATA_W + A_W
) (
   input  logic                clk,
   input  logic                rst,
   an_encoder_n13_if.slave     bus
);
   localparam int unsigned IDX_W = (A_W > 1) ? $clog2(A_W) : 1;
   localparam logic [A_W-1:0] A_BITS = A_W'(A);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(A_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW_W-1:0]  mcand;
   logic [CW_W-1:0]  mask;
   logic [CW_W-1:0]  acc;
   logic [CW_W-1:0]  acc_next;
   logic [IDX_W-1:0] idx;
   logic [CW_W-1:0]  codeword_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   always_comb begin
      acc_next = acc;
      if (A_BITS[idx]) acc_next = acc + (mcand << idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mcand       <= '0;
         mask        <= '0;
         acc         <= '0;
         idx         <= '0;
         codeword_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand      <= CW_W'(bus.data);
                  mask       <= bus.inj_mask;
                  acc        <= '0;
                  idx        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= CALC;
               end
            end
            CALC: begin
               acc <= acc_next;
               if (idx == IDX_LAST) begin
                  // Final partial product goes straight into the output register.
                  idx         <= '0;
                  codeword_q  <= acc_next ^ mask;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.codeword  = codeword_q;
   assign bus.busy      = busy_q;
endmodule

// File: doc/an_encoder_n13.md
# an_encoder_n13

Sequential AN-code encoder: multiplies a DATA_W-bit data word by the constant A (default 13) and emits the AN codeword `codeword = data * A`. The product is built by serial shift-and-add, one bit of A per cycle. It is the transmit-side counterpart of the Barrett-reduction AN decoder: any word it produces, with zero injection mask, decodes there to `q = data`, `r = 0`, `error = 0`. An optional XOR injection mask lets benches drive deliberate faults into the decoder path.

## Interface
- `DATA_W`, 3: data word width.
- `A`, 13: AN multiplier constant; must be odd and non-zero.
- `A_W`, 4: bit width of A; must satisfy `A < 2**A_W`.
- `CW_W`, DATA_W+A_W: codeword width; holds `(2**DATA_W-1)*A` without overflow.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  data word offered.
- `in_ready`  out  1  encoder can accept; high only in IDLE.
- `data`  in  DATA_W  data word, sampled on the accept edge.
- `inj_mask`  in  CW_W  XOR fault mask, sampled with `data`; 0 means a clean codeword.
- `out_valid`  out  1  `codeword` valid; held until consumed.
- `out_ready`  in  1  consumer accepts `codeword`.
- `codeword`  out  CW_W  `(data*A) ^ inj_mask`.
- `busy`  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE
  - `in_ready=1`.
  - On `in_valid && in_ready`: latch `data` into the multiplicand register (zero-extended to CW_W), latch `inj_mask`, clear the accumulator, set `idx=0`, go to CALC.
- CALC, one edge per bit of A, LSB first
  - If `A[idx]`, add `data << idx` to the accumulator; otherwise leave it unchanged. Zero bits still cost one cycle.
  - Increment `idx`.
  - After processing `idx = A_W-1`: load `codeword = acc_next ^ mask`, set `out_valid=1`, go to DONE.
- DONE
  - Hold `codeword` and `out_valid` stable.
  - On `out_valid && out_ready`: clear `out_valid`, go to IDLE.
- Arithmetic
  - Unsigned. The accumulator is CW_W wide, so overflow cannot occur for legal parameters.
  - `codeword` is registered; no combinational path from any input to any output.
- `in_valid` in CALC or DONE is ignored, since `in_ready=0` there. The input word is neither lost nor buffered: the producer must hold it.
- `out_ready` outside DONE has no effect.
- `codeword` keeps its last value after consumption; only `out_valid` qualifies it.
- Reset values, asynchronous on `rst` high:
  - state = IDLE, `in_ready=1`, `out_valid=0`, `busy=0`.
  - `codeword=0`, accumulator = 0, `idx=0`, mask register = 0.
- Reset mid-CALC or mid-DONE:
  - The in-flight word is discarded and no `out_valid` pulse is produced.
  - After `rst` falls, the first rising edge may accept a new word.

## Timing
- Accept edge E0, when `in_valid && in_ready`. In the same cycle after E0: `in_ready=0`, `busy=1`.
- CALC occupies edges E1..E_A_W. For A_W=4, `out_valid` and `codeword` are visible right after E4.
- Latency from accept edge to `out_valid` is A_W cycles, fixed and independent of the data value and of A's bit pattern.
- Consume edge Ec (`out_valid && out_ready`): after Ec, `out_valid=0`, `in_ready=1`, `busy=0`.
- Earliest next accept is Ec+1. Minimum period per word is A_W+2 cycles when `out_ready` is tied high.
- Backpressure: `out_ready` low for any number of cycles holds DONE with `codeword` unchanged.

## Test plan
- Clean encode sweep, A=13: `data` 0..7 with `inj_mask=0` gives `codeword` 0, 13, 26, 39, 52, 65, 78, 91.
  - Each `out_valid` must rise exactly 4 edges after its accept edge.
  - Cross-check each word through the decoder: `r=0`, `error=0`, `q=data`.
- Injection: `data=2`, `inj_mask=7'b0000001` gives `codeword=27`; the decoder must flag `error=1`. `data=3`, `inj_mask=7'b0000110` gives 39^6=33.
- Backpressure: `data=5`, `out_ready` held low for 6 cycles after `out_valid` rises.
  - `codeword=65` stays stable throughout and `in_ready` stays 0.
  - A changed `in_valid`/`data` presented during this window is not accepted.
- Back-to-back: `in_valid` high continuously with `data` 1 then 7 and `out_ready=1`.
  - Outputs are 13 then 91.
  - Second accept edge = first consume edge + 1.
  - Accept-to-accept spacing is 6 cycles.
- Reset mid-operation: accept `data=6`, assert `rst` asynchronously 2 edges later (between clock edges).
  - `out_valid`, `busy` and `codeword` go to 0 immediately, and `in_ready` to 1.
  - No stale output appears afterward.
  - A subsequent `data=4` yields 52.
